// File: rtl/tl_intersection_model_if.sv
// Light/sensor bus between a traffic light controller (master) and the
// intersection environment model (slave).
interface tl_intersection_model_if;
   logic [2:0] tl_sig_arr [4];
   logic [3:0] sensor;

   modport master (
      output tl_sig_arr,
      input  sensor
   );

   modport slave (
      input  tl_sig_arr,
      output sensor
   );
endinterface

// File: rtl/tl_intersection_model.sv
// Closed-loop intersection environment: per-approach car queues driven by arrivals and
// green-time departures, plus a light-protocol checker. Optional macro ARRIVAL_LFSR_EN.
module tl_intersection_model #(
   parameter int          QMAX      = 15,
   parameter int          DEP_CYC   = 20,
   parameter int          MIN_Y     = 30,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   localparam int         QW        = $clog2(QMAX + 1)
) (
   input  logic                  clk,
   input  logic                  arstN,
   tl_intersection_model_if.slave lights,
   input  logic [3:0]            arrive,
   input  logic                  err_clr,
   output logic [QW-1:0]         qlen [4],
   output logic [3:0]            err_sticky,
   output logic                  err_pulse,
   output logic [3:0]            q_ovf
);

   localparam int TW = $clog2(DEP_CYC + 1);
   localparam int YW = $clog2(MIN_Y + 1);

   localparam logic [TW-1:0] T_LAST = TW'(DEP_CYC - 1);
   localparam logic [YW-1:0] Y_SAT  = YW'(MIN_Y);
   localparam logic [QW-1:0] Q_SAT  = QW'(QMAX);

   localparam logic [2:0] L_OFF = 3'b000;
   localparam logic [2:0] L_G   = 3'b001;
   localparam logic [2:0] L_Y   = 3'b010;
   localparam logic [2:0] L_R   = 3'b100;

   logic [TW-1:0] dep_tmr    [4];
   logic [YW-1:0] y_cnt      [4];
   logic [2:0]    prev_light [4];
   logic [3:0]    dep;
   logic [3:0]    arr_evt;
   logic [3:0]    viol;
   logic [2:0]    gy_cnt;

   function automatic logic is_legal(input logic [2:0] l);
      return (l == L_OFF) || (l == L_G) || (l == L_Y) || (l == L_R);
   endfunction

   function automatic logic trans_ok(input logic [2:0] p, input logic [2:0] c);
      logic ok;
      ok = 1'b0;
      if ((p == L_OFF) || (c == L_OFF)) begin
         ok = 1'b1;
      end else begin
         case (p)
            L_G:     ok = (c == L_G) || (c == L_Y);
            L_Y:     ok = (c == L_Y) || (c == L_R);
            L_R:     ok = (c == L_R) || (c == L_G);
            default: ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

`ifdef ARRIVAL_LFSR_EN
   logic [15:0] lfsr;
   logic        unused_arrive;

   assign unused_arrive = ^arrive;

   // Fibonacci LFSR, taps 16,14,13,11; each nibble all-ones gives a 1/16 arrival rate.
   always_ff @(posedge clk or negedge arstN) begin
      if (!arstN) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   always_comb begin
      arr_evt = '0;
      for (int i = 0; i < 4; i++) begin
         arr_evt[i] = (lfsr[4*i +: 4] == 4'hF);
      end
   end
`else
   assign arr_evt = arrive;
`endif

   always_comb begin
      dep = '0;
      for (int i = 0; i < 4; i++) begin
         dep[i] = (lights.tl_sig_arr[i] == L_G) && (dep_tmr[i] == T_LAST) && (qlen[i] != '0);
      end
   end

   // Violations are judged on this edge's sample against the previous sample.
   always_comb begin
      viol   = '0;
      gy_cnt = '0;
      for (int i = 0; i < 4; i++) begin
         if (!is_legal(lights.tl_sig_arr[i])) begin
            viol[0] = 1'b1;
         end
         if ((lights.tl_sig_arr[i] == L_G) || (lights.tl_sig_arr[i] == L_Y)) begin
            gy_cnt = gy_cnt + 3'd1;
         end
         if (is_legal(lights.tl_sig_arr[i]) && is_legal(prev_light[i]) &&
             !trans_ok(prev_light[i], lights.tl_sig_arr[i])) begin
            viol[2] = 1'b1;
         end
         if ((prev_light[i] == L_Y) && (lights.tl_sig_arr[i] == L_R) && (y_cnt[i] < Y_SAT)) begin
            viol[3] = 1'b1;
         end
      end
      viol[1] = (gy_cnt > 3'd1);
   end

   always_comb begin
      lights.sensor = '0;
      for (int i = 0; i < 4; i++) begin
         lights.sensor[i] = (qlen[i] != '0);
      end
   end

   always_ff @(posedge clk or negedge arstN) begin
      if (!arstN) begin
         for (int i = 0; i < 4; i++) begin
            qlen[i]       <= '0;
            dep_tmr[i]    <= '0;
            y_cnt[i]      <= '0;
            prev_light[i] <= L_OFF;
         end
         err_sticky <= '0;
         err_pulse  <= 1'b0;
         q_ovf      <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (lights.tl_sig_arr[i] == L_G) begin
               dep_tmr[i] <= (dep_tmr[i] == T_LAST) ? '0 : dep_tmr[i] + TW'(1);
            end else begin
               dep_tmr[i] <= '0;
            end

            if (lights.tl_sig_arr[i] == L_Y) begin
               if (y_cnt[i] != Y_SAT) begin
                  y_cnt[i] <= y_cnt[i] + YW'(1);
               end
            end else begin
               y_cnt[i] <= '0;
            end

            // A simultaneous arrival and departure cancel out.
            if (arr_evt[i] && !dep[i]) begin
               if (qlen[i] == Q_SAT) begin
                  q_ovf[i] <= 1'b1;
               end else begin
                  qlen[i] <= qlen[i] + QW'(1);
               end
            end else if (dep[i] && !arr_evt[i]) begin
               qlen[i] <= qlen[i] - QW'(1);
            end

            prev_light[i] <= lights.tl_sig_arr[i];
         end
         err_pulse  <= |viol;
         err_sticky <= (err_clr ? 4'b0000 : err_sticky) | viol;
      end
   end

endmodule
